// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared sizing constants, the lane state encoding and a small
//               population-count helper for the demux_router slice.
// Contents    : NUM_LANES, DW, SW, INVALID_SEL, lane_state_e, popcount32()
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int NUM_LANES = 31;
    localparam int DW        = 2;
    localparam int SW        = 5;

    // Destination index with no lane behind it; symbols sent here are dropped.
    localparam logic [SW-1:0] INVALID_SEL = 5'd31;

    typedef enum logic [0:0] {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    // Number of set bits in a 32-bit vector (result fits in 6 bits).
    function automatic logic [5:0] popcount32(input logic [31:0] vec);
        logic [5:0] w_sum;
        w_sum = '0;
        for (int i = 0; i < 32; i++) begin
            w_sum = w_sum + {5'd0, vec[i]};
        end
        return w_sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_lane.sv
`default_nettype none
// ============================================================================
// Module      : demux_lane
// Description : One output lane of the router: a single holding register with
//               an EMPTY/FULL state machine and a valid/ack consumer handshake.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_load, i_data  - write a symbol into the lane
//               i_ack           - consumer takes the symbol (ignored if EMPTY)
//               o_valid, o_data - lane contents towards the consumer
//               o_ready         - lane can take a load this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module demux_lane #(
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_ack,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic          o_ready,
    output logic [DW-1:0] o_data
);
    import demux_pkg::*;

    lane_state_e   r_state;
    lane_state_e   w_state_nxt;
    logic [DW-1:0] r_data;
    logic [DW-1:0] w_data_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LANE_EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        case (r_state)
            LANE_EMPTY: begin
                if (i_load) begin
                    w_state_nxt = LANE_FULL;
                    w_data_nxt  = i_data;
                end
            end
            LANE_FULL: begin
                // A load while FULL only happens together with an ack, so the
                // lane simply takes the new symbol and stays FULL.
                if (i_load) begin
                    w_data_nxt = i_data;
                end else if (i_ack) begin
                    w_state_nxt = LANE_EMPTY;
                    w_data_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = LANE_EMPTY;
                w_data_nxt  = '0;
            end
        endcase
    end

    assign o_valid = (r_state == LANE_FULL);
    assign o_ready = (r_state == LANE_EMPTY) | i_ack;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/demux_router.sv
`default_nettype none
// ============================================================================
// Module      : demux_router
// Description : Registered 1-to-31 router for 2-bit symbols. A valid/ready
//               input is steered by a 5-bit destination into per-lane holding
//               registers presented with valid/ack. Destination 31 has no
//               lane: such symbols are consumed, dropped and flagged.
// Ports       : clk, reset                  - clock, synchronous active-high reset
//               in_valid/in_ready/in_sel/in_data - producer side
//               out_valid/out_data/out_ack  - per-lane consumer side
//               drop_err                    - one-cycle pulse per dropped symbol
//               occupancy                   - number of FULL lanes
//               drop_cnt                    - saturating drop counter
// Config      : DEMUX_DROP_CNT_EN - when defined, adds the drop_cnt port and
//               its 8-bit saturating register.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_router #(
    parameter int NUM_LANES = demux_pkg::NUM_LANES,
    parameter int DW        = demux_pkg::DW,
    parameter int SW        = demux_pkg::SW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SW-1:0]           in_sel,
    input  logic [DW-1:0]           in_data,
    output logic [NUM_LANES-1:0]    out_valid,
    output logic [NUM_LANES*DW-1:0] out_data,
    input  logic [NUM_LANES-1:0]    out_ack,
    output logic                    drop_err,
    output logic [4:0]              occupancy
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [7:0]              drop_cnt
`endif
);
    import demux_pkg::*;

    localparam int c_SEL_SPAN = 1 << SW;

    logic                  w_is_drop;
    logic                  w_accept;
    logic [NUM_LANES-1:0]  w_load;
    logic [NUM_LANES-1:0]  w_lane_ready;
    logic [c_SEL_SPAN-1:0] w_ready_ext;
    logic [NUM_LANES-1:0]  w_eff_ack;
    logic [5:0]            w_ack_cnt;
    logic [5:0]            w_occ_sum;
    logic [4:0]            r_occupancy;
    logic                  r_drop_err;

    assign w_is_drop = (in_sel == INVALID_SEL);
    assign w_accept  = in_valid & in_ready;

    // Indices without a lane always report ready so drops never stall.
    always_comb begin
        w_ready_ext                 = '1;
        w_ready_ext[NUM_LANES-1:0]  = w_lane_ready;
    end

    assign in_ready = w_ready_ext[in_sel];

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            localparam logic [SW-1:0] c_IDX = SW'(i);

            assign w_load[i] = w_accept & (in_sel == c_IDX);

            demux_lane #(
                .DW (DW)
            ) u_lane (
                .clk     (clk),
                .rst     (reset),
                .i_load  (w_load[i]),
                .i_ack   (out_ack[i]),
                .i_data  (in_data),
                .o_valid (out_valid[i]),
                .o_ready (w_lane_ready[i]),
                .o_data  (out_data[i*DW +: DW])
            );
        end
    endgenerate

    // Acks on EMPTY lanes do not count toward the occupancy decrement.
    assign w_eff_ack = out_ack & out_valid;
    assign w_ack_cnt = popcount32(32'(w_eff_ack));

    always_comb begin
        w_occ_sum = {1'b0, r_occupancy} + {5'd0, |w_load} - w_ack_cnt;
        if (w_occ_sum > 6'd31) begin
            w_occ_sum = 6'd31;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occupancy <= '0;
            r_drop_err  <= 1'b0;
        end else begin
            r_occupancy <= w_occ_sum[4:0];
            r_drop_err  <= w_accept & w_is_drop;
        end
    end

    assign occupancy = r_occupancy;
    assign drop_err  = r_drop_err;

`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_accept && w_is_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_router
// Description : Self-checking bench for demux_router. Directed scenarios plus
//               randomized traffic compared each cycle against an array-based
//               model of lane contents, drop pulses and drop counting.
//               Honours DEMUX_DROP_CNT_EN for the drop_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_router;
    import demux_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_sel;
    logic [1:0]  in_data;
    logic [30:0] out_valid;
    logic [61:0] out_data;
    logic [30:0] out_ack;
    logic        drop_err;
    logic [4:0]  occupancy;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    demux_router dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ack   (out_ack),
        .drop_err  (drop_err),
        .occupancy (occupancy)
`ifdef DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: what each lane holds, plus drop bookkeeping.
    bit         m_full [31];
    logic [1:0] m_data [31];
    int         m_drops;
    bit         m_drop_pulse;

    int   n_checks = 0;
    int   n_errors = 0;
    logic seen_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_ready(input logic [4:0] sel, input logic [30:0] ack);
        if (sel == 5'd31) return 1'b1;
        return (!m_full[sel]) || ack[sel];
    endfunction

    // One clock cycle: drive at negedge, check in_ready, apply the edge to the
    // model, then check every registered output just after the edge.
    task automatic step(input logic v, input logic [4:0] sel, input logic [1:0] d,
                        input logic [30:0] ack, input logic rst);
        logic        exp_rdy;
        logic [30:0] ev;
        logic [61:0] ed;
        int          occ;
        @(negedge clk);
        reset    = rst;
        in_valid = v;
        in_sel   = sel;
        in_data  = d;
        out_ack  = ack;
        #1;
        exp_rdy    = model_ready(sel, ack);
        seen_ready = in_ready;
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 31; i++) begin
                m_full[i] = 0;
                m_data[i] = 2'b00;
            end
            m_drops      = 0;
            m_drop_pulse = 0;
        end else begin
            for (int i = 0; i < 31; i++) begin
                if (m_full[i] && ack[i]) begin
                    m_full[i] = 0;
                    m_data[i] = 2'b00;
                end
            end
            m_drop_pulse = 0;
            if (v && exp_rdy) begin
                if (sel == 5'd31) begin
                    m_drop_pulse = 1;
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_full[sel] = 1;
                    m_data[sel] = d;
                end
            end
        end
        #1;
        occ = 0;
        for (int i = 0; i < 31; i++) begin
            ev[i]         = m_full[i];
            ed[2*i +: 2]  = m_data[i];
            occ           += m_full[i] ? 1 : 0;
        end
        check("out_valid", {33'd0, out_valid}, {33'd0, ev});
        check("out_data", {2'd0, out_data}, {2'd0, ed});
        check("occupancy", {59'd0, occupancy}, 64'(occ));
        check("drop_err", {63'd0, drop_err}, {63'd0, m_drop_pulse});
`ifdef DEMUX_DROP_CNT_EN
        check("drop_cnt", {56'd0, drop_cnt}, 64'(m_drops));
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [30:0] one;
        logic [4:0]  rsel;
        one      = 31'd1;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sel   = '0;
        in_data  = '0;
        out_ack  = '0;
        m_drops  = 0;
        m_drop_pulse = 0;
        for (int i = 0; i < 31; i++) begin
            m_full[i] = 0;
            m_data[i] = 2'b00;
        end

        // Reset state
        step(1'b0, 5'd0, 2'b00, '0, 1'b1);
        step(1'b0, 5'd0, 2'b00, '0, 1'b1);
        check("rst_valid", {33'd0, out_valid}, 64'd0);
        check("rst_occ", {59'd0, occupancy}, 64'd0);

        // Single accept into lane 12
        step(1'b1, 5'd12, 2'b10, '0, 1'b0);
        check("t1_ready", {63'd0, seen_ready}, 64'd1);
        check("t1_valid", {33'd0, out_valid}, {33'd0, one << 12});
        check("t1_data", {62'd0, out_data[25:24]}, 64'd2);
        check("t1_occ", {59'd0, occupancy}, 64'd1);

        // Backpressure confined to a full, un-acked lane
        step(1'b1, 5'd30, 2'b01, '0, 1'b0);
        step(1'b1, 5'd30, 2'b11, '0, 1'b0);
        check("t2_block", {63'd0, seen_ready}, 64'd0);
        check("t2_held", {62'd0, out_data[61:60]}, 64'd1);
        step(1'b1, 5'd5, 2'b10, '0, 1'b0);
        check("t2_other_ready", {63'd0, seen_ready}, 64'd1);
        check("t2_lane5", {62'd0, out_data[11:10]}, 64'd2);
        check("t2_lane30", {62'd0, out_data[61:60]}, 64'd1);

        // Ack and reload in the same cycle
        step(1'b1, 5'd7, 2'b10, '0, 1'b0);
        step(1'b1, 5'd7, 2'b01, one << 7, 1'b0);
        check("t3_ready", {63'd0, seen_ready}, 64'd1);
        check("t3_valid7", {63'd0, out_valid[7]}, 64'd1);
        check("t3_data7", {62'd0, out_data[15:14]}, 64'd1);
        check("t3_occ", {59'd0, occupancy}, 64'd4);

        // Drops to the invalid destination
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 5'd31, 2'b11, '0, 1'b0);
            check("t4_ready", {63'd0, seen_ready}, 64'd1);
            check("t4_drop_err", {63'd0, drop_err}, 64'd1);
        end
        check("t4_occ", {59'd0, occupancy}, 64'd4);
`ifdef DEMUX_DROP_CNT_EN
        check("t4_cnt3", {56'd0, drop_cnt}, 64'd3);
`endif
        step(1'b0, 5'd31, 2'b11, '0, 1'b0);
        check("t4_drop_idle", {63'd0, drop_err}, 64'd0);
        for (int k = 0; k < 300; k++) step(1'b1, 5'd31, 2'b00, '0, 1'b0);
`ifdef DEMUX_DROP_CNT_EN
        check("t4_cnt_sat", {56'd0, drop_cnt}, 64'd255);
`endif

        // Fill every lane, then ack three at once
        for (int i = 0; i < 31; i++) step(1'b1, 5'(i), 2'(i + 1), '0, 1'b0);
        check("t5_full", {59'd0, occupancy}, 64'd31);
        step(1'b0, 5'd0, 2'b00, 31'h7, 1'b0);
        check("t5_occ28", {59'd0, occupancy}, 64'd28);
        check("t5_data_clr", {58'd0, out_data[5:0]}, 64'd0);

        // Reset beats a concurrent accept and ack
        step(1'b0, 5'd0, 2'b00, one << 4, 1'b0);
        step(1'b1, 5'd4, 2'b10, one << 9, 1'b1);
        check("t6_valid", {33'd0, out_valid}, 64'd0);
        check("t6_data", {2'd0, out_data}, 64'd0);
        check("t6_occ", {59'd0, occupancy}, 64'd0);
        check("t6_drop", {63'd0, drop_err}, 64'd0);
        step(1'b0, 5'd4, 2'b10, '0, 1'b0);
        check("t6_not_stored", {63'd0, out_valid[4]}, 64'd0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rsel = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            step(($urandom_range(0, 3) != 0), rsel, 2'($urandom),
                 31'($urandom & $urandom & $urandom), ($urandom_range(0, 499) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_router.md
# demux_router

Registered 1-to-31 router for 2-bit symbols and the return path of the 31:1 `mux` selector. It takes one symbol per cycle on a valid/ready input, steered by a 5-bit destination index. It parks the symbol in a per-lane holding register and presents it to lane consumers with a valid/ack handshake. Destination 31 has no lane, so those symbols are consumed, dropped and flagged.

## Interface
- `NUM_LANES`, default 31: number of output lanes; index 31 is reserved as invalid.
- `DW`, default 2: symbol width.
- `SW`, default 5: selector width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset; the only clock and reset in the block.
- `in_valid`  in  1  the producer offers a symbol.
- `in_ready`  out  1  the router accepts the symbol this cycle.
- `in_sel`  in  SW  destination lane index.
- `in_data`  in  DW  symbol.
- `out_valid`  out  NUM_LANES  bit i set: lane i holds a symbol.
- `out_data`  out  NUM_LANES*DW  lane i is bits [2i+1:2i].
- `out_ack`  in  NUM_LANES  bit i set: the consumer takes lane i this cycle; ignored while `out_valid[i]`=0.
- `drop_err`  out  1  one-cycle pulse when an invalid-destination symbol is consumed.
- `occupancy`  out  5  number of full lanes, 0..31.
- `drop_cnt`  out  8  saturating drop counter; present only under `DEMUX_DROP_CNT_EN`.

## Operation
- Each lane is a 2-state FSM:
  - EMPTY→FULL on load.
  - FULL→EMPTY on `out_ack` with no load.
  - FULL→FULL with new data on simultaneous ack and load.
  - EMPTY with ack: no change.
- `in_ready` is combinational:
  - 1 when `in_sel`==31.
  - Otherwise 1 when lane `in_sel` is EMPTY, or FULL with `out_ack[in_sel]`=1 this cycle.
  - It does not depend on `in_valid`.
- Accept = `in_valid & in_ready`.
  - Accept with a valid selector: the lane loads `in_data` at the next edge.
  - Accept with `in_sel`==31: nothing is stored; `drop_err`=1 on the next cycle for exactly one cycle.
- At most one load per cycle; any number of acks per cycle.
- `out_data[i]` holds its value while FULL. Its value while EMPTY is don't-care, but the implementation clears it to 0 on ack without reload.
- `occupancy` is registered: next = current + load − (number of effective acks), computed at 6 bits and never exceeding 31.
- Reset sets `out_valid`=0, `out_data`=0, `drop_err`=0, `occupancy`=0, `drop_cnt`=0.
- Reset wins over any concurrent accept or ack. A symbol offered in a reset cycle is lost, and the producer must re-present it.

## Timing
- Latency from accept edge to `out_valid[i]`=1 is 1 cycle.
- Lane throughput: 1 symbol/cycle with a continuous ack (ack-and-reload in the same cycle).
- Router throughput: 1 symbol/cycle when the targeted lanes have space.
- Backpressure is confined to the addressed lane; a FULL, un-acked lane never blocks symbols for other lanes.
- Producer rule: hold `in_sel` and `in_data` stable while `in_valid`=1 and `in_ready`=0.
- `drop_err` and `drop_cnt` update one cycle after the drop accept.

## Configuration
- `DEMUX_DROP_CNT_EN` defined:
  - The `drop_cnt` port and register exist.
  - The register increments on every drop and saturates at 255.
  - It clears only on reset.
- Macro undefined:
  - The port and register are absent.
  - `drop_err` still pulses.
  - All other behaviour is identical.

## Structure
- `demux_pkg` holds:
  - `NUM_LANES`, `DW`, `SW`.
  - `INVALID_SEL` = 5'd31.
  - the lane state enum {LANE_EMPTY, LANE_FULL}.
- Sub-module `demux_lane` is one holding register with its FSM (load, ack → valid, data).
- `demux_router` instantiates 31 `demux_lane` instances through a generate loop and adds:
  - the decode logic,
  - the `in_ready` mux,
  - the occupancy logic,
  - the drop logic.

## Test plan
- Reset, then `in_sel`=12, `in_data`=2'b10, one cycle → `in_ready`=1; next cycle `out_valid`=1<<12 and lane 12 data=2'b10; `occupancy`=1.
- Lane 30 FULL and un-acked; offer `in_sel`=30 → `in_ready`=0 and data held. Also offer `in_sel`=5 → accepted, lane 5 loads, lane 30 unchanged.
- Lane 7 FULL; same-cycle `out_ack[7]`=1 and offer `in_sel`=7 with 2'b01 → `in_ready`=1; lane 7 stays valid with 2'b01; `occupancy` unchanged.
- `in_sel`=31, `in_data`=2'b11, 3 consecutive cycles → `in_ready`=1 throughout; `drop_err` high 3 cycles; `out_valid` all 0; with the macro, `drop_cnt`=3, and after 300 drops `drop_cnt`=255.
- Fill all 31 lanes → `occupancy`=31. Ack lanes 0, 1, 2 in one cycle → `occupancy`=28 and those lanes' `out_data`=0.
- Assert `reset` while accepting into lane 4 and acking lane 9 → all outputs 0 the next cycle, and the lane 4 symbol is not stored.
